// File: rtl/stream_arb_pkg.sv
// Shared types, default widths and helpers for the stream round-robin arbiter.
package stream_arb_pkg;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_DATA_WIDTH = 8;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 32'd1 : 32'($clog2(n));
  endfunction

  // Packet-lock state: IDLE arbitrates freely, LOCKED pins the grant.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/rr_arb_core.sv
// Combinational round-robin grant: first request at or after the pointer,
// or the locked index when a packet lock is active.
module rr_arb_core
  import stream_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned SRC_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SRC_W-1:0]   ptr_i,
  input  logic               lock_i,
  input  logic [SRC_W-1:0]   lock_idx_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [SRC_W-1:0]   grant_idx_o
);

  logic [SRC_W:0]   sum;
  logic [SRC_W-1:0] cand;
  logic             found;

  // Rotating priority search; the pointer is always < NUM_REQ so one wrap suffices.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    sum         = '0;
    cand        = '0;
    found       = 1'b0;
    if (lock_i) begin
      grant_o[lock_idx_i] = 1'b1;
      grant_idx_o         = lock_idx_i;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        sum = {1'b0, ptr_i} + (SRC_W+1)'(k);
        if (sum >= (SRC_W+1)'(NUM_REQ)) begin
          sum = sum - (SRC_W+1)'(NUM_REQ);
        end
        cand = sum[SRC_W-1:0];
        if (!found && req_i[cand]) begin
          found         = 1'b1;
          grant_o[cand] = 1'b1;
          grant_idx_o   = cand;
        end
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output stream among
// NUM_REQ requesters, with a main+skid output stage so in_ready_o never
// depends combinationally on out_ready_i.
// Optional packet lock (in_last_i/out_last_o) is enabled with `define ARB_LOCK_EN.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int unsigned SRC_W      = idx_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            in_valid_i,
  output logic [NUM_REQ-1:0]            in_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data_i,
`ifdef ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            in_last_i,
  output logic                          out_last_o,
`endif
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic [SRC_W-1:0]              out_src_o
);

  logic [NUM_REQ-1:0]    grant;
  logic [SRC_W-1:0]      gidx;
  logic [SRC_W-1:0]      ptr_q, ptr_d;
  logic [SRC_W-1:0]      ptr_next;
  logic                  lock_active;
  logic [SRC_W-1:0]      lock_idx;
  logic                  accept;
  logic                  advance;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  ready_q, ready_d;
  logic                  main_valid_q, main_valid_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [SRC_W-1:0]      main_src_q, main_src_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SRC_W-1:0]      skid_src_q, skid_src_d;
  logic                  out_fire;

`ifdef ARB_LOCK_EN
  logic                  sel_last;
  logic                  main_last_q, main_last_d;
  logic                  skid_last_q, skid_last_d;
  lock_state_e           state_q, state_d;
  logic [SRC_W-1:0]      lock_idx_q, lock_idx_d;
`endif

  rr_arb_core #(
    .NUM_REQ (NUM_REQ)
  ) u_core (
    .req_i       (in_valid_i),
    .ptr_i       (ptr_q),
    .lock_i      (lock_active),
    .lock_idx_i  (lock_idx),
    .grant_o     (grant),
    .grant_idx_o (gidx)
  );

  // Ready is forced low during reset; otherwise only the granted, valid requester sees it.
  assign in_ready_o = rst ? '0 : (grant & in_valid_i & {NUM_REQ{ready_q}});
  assign accept     = |in_ready_o;
  assign out_fire   = main_valid_q & out_ready_i;
  assign ptr_next   = (gidx == SRC_W'(NUM_REQ - 1)) ? '0 : gidx + SRC_W'(1);

  // Payload mux of the granted requester.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      sel_data = sel_data | (in_data_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}});
    end
  end

`ifdef ARB_LOCK_EN
  assign sel_last    = |(in_last_i & grant);
  assign lock_active = (state_q == LOCKED);
  assign lock_idx    = lock_idx_q;
  assign advance     = accept & sel_last;

  // Lock FSM next state: enter on a non-last accept, leave on the last beat.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      IDLE: begin
        if (accept && !sel_last) begin
          state_d    = LOCKED;
          lock_idx_d = gidx;
        end
      end
      LOCKED: begin
        if (accept && sel_last) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`else
  assign lock_active = 1'b0;
  assign lock_idx    = '0;
  assign advance     = accept;
`endif

  // Pointer moves past the requester whose beat (or packet) just completed.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = ptr_next;
    end
  end

  // Main/skid stage next state; skid fills only when main is stalled.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_src_d   = main_src_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_src_d   = skid_src_q;
    ready_d      = ready_q;
`ifdef ARB_LOCK_EN
    main_last_d  = main_last_q;
    skid_last_d  = skid_last_q;
`endif
    if (out_fire) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_src_d   = skid_src_q;
        skid_valid_d = 1'b0;
        skid_data_d  = '0;
        skid_src_d   = '0;
        ready_d      = 1'b1;
`ifdef ARB_LOCK_EN
        main_last_d  = skid_last_q;
        skid_last_d  = 1'b0;
`endif
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = sel_data;
        main_src_d   = gidx;
`ifdef ARB_LOCK_EN
        main_last_d  = sel_last;
`endif
      end else begin
        main_valid_d = 1'b0;
        main_data_d  = '0;
        main_src_d   = '0;
`ifdef ARB_LOCK_EN
        main_last_d  = 1'b0;
`endif
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = sel_data;
        main_src_d   = gidx;
`ifdef ARB_LOCK_EN
        main_last_d  = sel_last;
`endif
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = sel_data;
        skid_src_d   = gidx;
        ready_d      = 1'b0;
`ifdef ARB_LOCK_EN
        skid_last_d  = sel_last;
`endif
      end
    end
  end

  // Pointer, ready flag and main/skid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      ready_q      <= 1'b1;
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_src_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_src_q   <= '0;
`ifdef ARB_LOCK_EN
      main_last_q  <= 1'b0;
      skid_last_q  <= 1'b0;
`endif
    end else begin
      ptr_q        <= ptr_d;
      ready_q      <= ready_d;
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_src_q   <= main_src_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_src_q   <= skid_src_d;
`ifdef ARB_LOCK_EN
      main_last_q  <= main_last_d;
      skid_last_q  <= skid_last_d;
`endif
    end
  end

  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;
  assign out_src_o   = main_src_q;
`ifdef ARB_LOCK_EN
  assign out_last_o  = main_last_q;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: vector table, reset/lock sequences, and a
// randomized run against a queue-based reference model.
module tb_stream_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [N*DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_src;
`ifdef ARB_LOCK_EN
  logic [N-1:0]  in_last;
  logic          out_last;
`endif

  stream_rr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
`ifdef ARB_LOCK_EN
    .in_last_i   (in_last),
    .out_last_o  (out_last),
`endif
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_src_o   (out_src)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        oready;
    logic [3:0]  exp_rdy;
    logic        exp_v;
    logic [7:0]  exp_d;
    logic [1:0]  exp_s;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] s;
  } beat_t;

  vec_t  tbl[20];
  beat_t mq[$];
  int    mptr;
  int    txseq[N];
  int    rxseq[N];
  int    waitc[N];
  logic [N-1:0] acc_d;
  logic [N-1:0] exp_rdy;
  bit    found;
  int    idx;

  initial begin
    // Round robin over four always-valid requesters, then a lone requester 2.
    tbl[0]  = '{4'hF, 32'h13121110, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0};
    tbl[1]  = '{4'hF, 32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd0};
    tbl[2]  = '{4'hF, 32'h13121110, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd1};
    tbl[3]  = '{4'hF, 32'h13121110, 1'b1, 4'b1000, 1'b1, 8'h12, 2'd2};
    tbl[4]  = '{4'hF, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h13, 2'd3};
    tbl[5]  = '{4'hF, 32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd0};
    tbl[6]  = '{4'h4, 32'h00200000, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd1};
    tbl[7]  = '{4'h4, 32'h00210000, 1'b1, 4'b0100, 1'b1, 8'h20, 2'd2};
    tbl[8]  = '{4'h4, 32'h00220000, 1'b1, 4'b0100, 1'b1, 8'h21, 2'd2};
    tbl[9]  = '{4'h4, 32'h00230000, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd2};
    tbl[10] = '{4'h4, 32'h00240000, 1'b1, 4'b0100, 1'b1, 8'h23, 2'd2};
    tbl[11] = '{4'h0, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'h24, 2'd2};
    tbl[12] = '{4'h0, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
    // Skid: sink stalls for three cycles while requester 0 streams A1..A3.
    tbl[13] = '{4'h1, 32'h000000A1, 1'b0, 4'b0001, 1'b0, 8'h00, 2'd0};
    tbl[14] = '{4'h1, 32'h000000A2, 1'b0, 4'b0001, 1'b1, 8'hA1, 2'd0};
    tbl[15] = '{4'h1, 32'h000000A3, 1'b0, 4'b0000, 1'b1, 8'hA1, 2'd0};
    tbl[16] = '{4'h1, 32'h000000A3, 1'b1, 4'b0000, 1'b1, 8'hA1, 2'd0};
    tbl[17] = '{4'h1, 32'h000000A3, 1'b1, 4'b0001, 1'b1, 8'hA2, 2'd0};
    tbl[18] = '{4'h0, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'hA3, 2'd0};
    tbl[19] = '{4'h0, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};

    // Reset with requesters valid: ready must stay low.
    rst       = 1'b1;
    in_valid  = 4'hF;
    in_data   = 32'h13121110;
    out_ready = 1'b1;
`ifdef ARB_LOCK_EN
    in_last   = '1;
`endif
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_src",   32'(out_src),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    next_cycle();
    rst = 1'b0;

    for (int r = 0; r < 20; r++) begin
      in_valid  = tbl[r].valid;
      in_data   = tbl[r].data;
      out_ready = tbl[r].oready;
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", r),  32'(in_ready),  32'(tbl[r].exp_rdy));
      chk($sformatf("tbl%0d_out_valid", r), 32'(out_valid), 32'(tbl[r].exp_v));
      chk($sformatf("tbl%0d_out_data", r),  32'(out_data),  32'(tbl[r].exp_d));
      chk($sformatf("tbl%0d_out_src", r),   32'(out_src),   32'(tbl[r].exp_s));
      next_cycle();
    end

    // Reset asserted mid-stream with main and skid occupied.
    in_valid  = 4'h1;
    in_data   = 32'h000000B1;
    out_ready = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data",  32'(out_data),  32'd0);
    chk("mid_rst_out_src",   32'(out_src),   32'd0);
    chk("mid_rst_in_ready",  32'(in_ready),  32'd0);
    next_cycle();
    rst      = 1'b0;
    in_valid = 4'h0;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    next_cycle();

`ifdef ARB_LOCK_EN
    // Requester 0 sends a 3-beat packet while requester 1 waits.
    out_ready = 1'b1;
    in_valid  = 4'b0011;
    in_data   = 32'h0000B001;
    in_last   = 4'b0010;
    @(negedge clk);
    chk("lock_b1_ready", 32'(in_ready), 32'b0001);
    next_cycle();
    in_valid = 4'b0010;
    @(negedge clk);
    chk("lock_hold_ready", 32'(in_ready), 32'b0000);
    chk("lock_b1_data",    32'(out_data), 32'h01);
    chk("lock_b1_last",    32'(out_last), 32'd0);
    next_cycle();
    in_valid = 4'b0011;
    in_data  = 32'h0000B002;
    @(negedge clk);
    chk("lock_b2_ready", 32'(in_ready), 32'b0001);
    next_cycle();
    in_data = 32'h0000B003;
    in_last = 4'b0011;
    @(negedge clk);
    chk("lock_b3_ready", 32'(in_ready), 32'b0001);
    chk("lock_b2_data",  32'(out_data), 32'h02);
    chk("lock_b2_last",  32'(out_last), 32'd0);
    next_cycle();
    in_valid = 4'b0010;
    @(negedge clk);
    chk("lock_r1_ready", 32'(in_ready), 32'b0010);
    chk("lock_b3_data",  32'(out_data), 32'h03);
    chk("lock_b3_last",  32'(out_last), 32'd1);
    next_cycle();
    in_valid = 4'b0000;
    @(negedge clk);
    chk("lock_r1_data", 32'(out_data), 32'hB0);
    chk("lock_r1_src",  32'(out_src),  32'd1);
    next_cycle();
    in_last = '1;
`endif

    // Randomized traffic against the reference model.
    rst      = 1'b1;
    in_valid = '0;
    in_data  = '0;
    next_cycle();
    rst   = 1'b0;
    mq.delete();
    mptr  = 0;
    acc_d = '0;
    for (int i = 0; i < N; i++) begin
      txseq[i] = 0;
      rxseq[i] = 0;
      waitc[i] = 0;
    end

    for (int cyc = 0; cyc < 1010; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (acc_d[i]) begin
          in_valid[i] = 1'b0;
          txseq[i]++;
        end
        if (cyc < 1000 && !in_valid[i] && $urandom_range(0, 3) != 0) begin
          in_valid[i]         = 1'b1;
          in_data[i*DW +: DW] = {2'(i), 6'(txseq[i])};
          waitc[i]            = 0;
        end
      end
      out_ready = (cyc >= 1000) ? 1'b1 : ($urandom_range(0, 2) != 0);
      @(negedge clk);

      // Model: two-deep buffer, ready while fewer than two beats are held.
      exp_rdy = '0;
      found   = 1'b0;
      if (mq.size() < 2) begin
        for (int k = 0; k < N; k++) begin
          idx = (mptr + k) % N;
          if (!found && in_valid[idx]) begin
            found        = 1'b1;
            exp_rdy[idx] = 1'b1;
          end
        end
      end
      chk("rnd_in_ready",  32'(in_ready),  32'(exp_rdy));
      chk("rnd_out_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("rnd_out_data",  32'(out_data),  (mq.size() > 0) ? 32'(mq[0].d) : 32'd0);
      chk("rnd_out_src",   32'(out_src),   (mq.size() > 0) ? 32'(mq[0].s) : 32'd0);

      // Per-source ordering of delivered beats.
      if (out_valid && out_ready) begin
        chk("rnd_rx_seq", 32'(out_data), 32'({out_src, 6'(rxseq[out_src])}));
        rxseq[out_src]++;
      end

      // Fairness from observed handshakes.
      acc_d = in_valid & in_ready;
      for (int j = 0; j < N; j++) begin
        if (acc_d[j]) begin
          chk("rnd_fair_wait", 32'(waitc[j] <= N - 1), 32'd1);
          waitc[j] = 0;
          for (int i = 0; i < N; i++) begin
            if (i != j && in_valid[i]) waitc[i]++;
          end
        end
      end

      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      for (int i = 0; i < N; i++) begin
        if (exp_rdy[i]) begin
          mq.push_back('{d: in_data[i*DW +: DW], s: 2'(i)});
          mptr = (i + 1) % N;
        end
      end
      next_cycle();
    end

    for (int i = 0; i < N; i++) begin
      chk($sformatf("rnd_count_src%0d", i), 32'(rxseq[i]), 32'(txseq[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
